ram_cmd_arbiter: RTL and testbench
==================================

Name: ram_cmd_arbiter

Overview:
- Shares the single 10-bit-command RAM port between two independent requesters, req0 and req1.
- Each requester issues simple read or write transactions with an 8-bit address and 8-bit data.
- The block serialises each transaction into the RAM command sequence, round-robin arbitrates between requesters, and returns a per-requester response.
- RAM command sequence: {00,addr} then {01,data} for a write; {10,addr} then {11,xx} for a read.
- Sits between the SPI/host front-ends and the RAM.

Parameters:
- ADDR_SIZE, 8, width of requester address and RAM address field; must be 8 to match the command format.
- RD_TIMEOUT, 4, maximum cycles spent in RD_WAIT without ram_tx_valid before an error response is returned; legal range 1..15.
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, req0 always wins.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has a transaction.
- req0_ready  out  1  requester 0 transaction accepted this cycle.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  8  RAM address.
- req0_wdata  in  8  write data.
- rsp0_valid  out  1  one-cycle response pulse to requester 0.
- rsp0_rdata  out  8  read data; 0 for writes and errors.
- rsp0_err  out  1  read timed out; valid with rsp0_valid.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata, rsp1_err: same as above, for requester 1.
- ram_din  out  10  command word to RAM: [9:8] opcode, [7:0] payload.
- ram_rx_valid  out  1  command word valid.
- ram_dout  in  8  RAM read data.
- ram_tx_valid  in  1  RAM read data valid.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; all registered outputs 0 (ram_din, ram_rx_valid, rsp*_valid, rsp*_rdata, rsp*_err); last_grant=1 so req0 wins first; timeout counter 0. Reset mid-transaction abandons it with no response.
- FSM states: IDLE, CMD_ADDR, CMD_DATA, CMD_READ, RD_WAIT, RESP.
- reqN_ready: combinational; high only in IDLE for the selected requester.
- Selection with only one valid: that requester is selected.
- Selection with both valid: RR_EN=1 picks the requester not in last_grant; RR_EN=0 picks req0.
- Acceptance: on valid&ready, capture we/addr/wdata and owner, update last_grant, go to CMD_ADDR. Requester fields need not be held afterwards.
- CMD_ADDR (1 cycle): ram_rx_valid=1, ram_din={we?2'b00:2'b10, addr}. Next state is CMD_DATA for a write, CMD_READ for a read.
- CMD_DATA (1 cycle): ram_rx_valid=1, ram_din={2'b01, wdata}; then RESP with rdata=0, err=0.
- CMD_READ (1 cycle): ram_rx_valid=1, ram_din={2'b11, 8'h00}; then RD_WAIT, counter cleared.
- RD_WAIT: ram_rx_valid=0. If ram_tx_valid, latch ram_dout and go to RESP. Otherwise increment the counter; when the counter reaches RD_TIMEOUT, go to RESP with rdata=0, err=1. ram_tx_valid is sampled only in RD_WAIT, because the RAM's tx_valid is sticky across commands.
- RESP (1 cycle): owner's rspN_valid=1 with rdata/err; the other requester's rsp stays 0; then IDLE.
- ram_din: ram_din=0 whenever ram_rx_valid=0. Command ram_din/ram_rx_valid are registered outputs.
- Latency, accept edge to rsp_valid high: write 3 cycles (accept at T, commands at T+1 and T+2, rsp at T+3); read 4 cycles nominal (RD_WAIT at T+3, rsp at T+4).
- No new acceptance until IDLE: at most one outstanding transaction.
- A requester may present a new request in the same cycle as its rsp_valid; it is considered the following IDLE cycle.
- Address order: the write address is always re-issued before data, so interleaved owners never corrupt the RAM's internal address registers.

Test Plan:
- Write then read, single requester: req0 write addr 0x3C data 0xA5, then read 0x3C. Required RAM words 0x03C then 0x1A5; then 0x23C then 0x300; rsp0_rdata=0xA5, err=0. Write rsp at accept+3, read rsp at accept+4.
- Simultaneous requests, RR_EN=1: both valid continuously after reset. Grants alternate req0, req1, req0, req1; each rsp goes only to its owner.
- Fixed priority, RR_EN=0: both valid continuously. Only req0 is granted while its valid is held; req1 is granted on the first IDLE cycle with req0_valid=0.
- Read timeout: RAM model holds ram_tx_valid=0, RD_TIMEOUT=4. rsp_valid=1, err=1, rdata=0x00 after 4 cycles in RD_WAIT; FSM then returns to IDLE.
- Stale tx_valid: RAM model leaves tx_valid=1 from a prior read, then a write is issued. No read capture occurs; the write rsp has rdata=0.
- Reset mid-read: assert rst_n=0 during CMD_READ. Next cycle all outputs 0; no rsp is issued; the next req0 is granted first.

Source files
------------

// File: rtl/ram_cmd_arbiter.sv
// Two-requester front end for the shared 10-bit-command RAM port: arbitrates,
// serialises each transaction into RAM command words, and returns a response.
module ram_cmd_arbiter #(
  parameter int ADDR_SIZE  = 8,
  parameter int RD_TIMEOUT = 4,
  parameter int RR_EN      = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_we,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [7:0]           req0_wdata,
  output logic                 rsp0_valid,
  output logic [7:0]           rsp0_rdata,
  output logic                 rsp0_err,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_we,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [7:0]           req1_wdata,
  output logic                 rsp1_valid,
  output logic [7:0]           rsp1_rdata,
  output logic                 rsp1_err,
  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD_ADDR = 3'd1,
    CMD_DATA = 3'd2,
    CMD_READ = 3'd3,
    RD_WAIT  = 3'd4,
    RESP     = 3'd5
  } state_t;

  localparam logic [3:0] TO_LAST = 4'(RD_TIMEOUT - 1);

  state_t     state;
  logic       owner;
  logic       last_grant;
  logic       cap_we;
  logic [7:0] cap_wdata;
  logic [3:0] to_cnt;

  logic       sel1;
  logic       grant0;
  logic       grant1;
  logic       fin;
  logic [7:0] fin_data;
  logic       fin_err;

  // Handshake: a request transfers on the rising edge where reqN_valid and
  // reqN_ready are both high; ready depends only on state, last_grant and the
  // two valids, and only one requester can see ready in any cycle.
  always_comb begin
    sel1 = 1'b0;
    if (req0_valid && req1_valid) begin
      sel1 = (RR_EN != 0) ? ~last_grant : 1'b0;
    end else begin
      sel1 = req1_valid;
    end
    grant0 = (state == IDLE) && req0_valid && !sel1;
    grant1 = (state == IDLE) && req1_valid && sel1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign dbg_state  = state;

  // fin marks the cycle whose edge loads the owner's response registers.
  always_comb begin
    fin      = 1'b0;
    fin_data = 8'h00;
    fin_err  = 1'b0;
    case (state)
      CMD_DATA: fin = 1'b1;
      RD_WAIT: begin
        if (ram_tx_valid) begin
          fin      = 1'b1;
          fin_data = ram_dout;
        end else if (to_cnt == TO_LAST) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      cap_we       <= 1'b0;
      cap_wdata    <= 8'h00;
      to_cnt       <= 4'd0;
      ram_din      <= 10'h000;
      ram_rx_valid <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp0_rdata   <= 8'h00;
      rsp0_err     <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp1_rdata   <= 8'h00;
      rsp1_err     <= 1'b0;
    end else begin
      ram_din      <= 10'h000;
      ram_rx_valid <= 1'b0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;

      if (fin) begin
        if (owner) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= fin_data;
          rsp1_err   <= fin_err;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= fin_data;
          rsp0_err   <= fin_err;
        end
      end

      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner        <= grant1;
            last_grant   <= grant1;
            cap_we       <= grant1 ? req1_we : req0_we;
            cap_wdata    <= grant1 ? req1_wdata : req0_wdata;
            ram_rx_valid <= 1'b1;
            if (grant1) begin
              ram_din <= {(req1_we ? 2'b00 : 2'b10), req1_addr};
            end else begin
              ram_din <= {(req0_we ? 2'b00 : 2'b10), req0_addr};
            end
            state <= CMD_ADDR;
          end
        end
        CMD_ADDR: begin
          ram_rx_valid <= 1'b1;
          if (cap_we) begin
            ram_din <= {2'b01, cap_wdata};
            state   <= CMD_DATA;
          end else begin
            ram_din <= {2'b11, 8'h00};
            state   <= CMD_READ;
          end
        end
        CMD_DATA: state <= RESP;
        CMD_READ: begin
          to_cnt <= 4'd0;
          state  <= RD_WAIT;
        end
        RD_WAIT: begin
          if (fin) begin
            state <= RESP;
          end else begin
            to_cnt <= to_cnt + 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter: a round-robin instance with a small RAM
// model, plus a fixed-priority instance for the priority scenario.
module tb_ram_cmd_arbiter;

  logic clk;
  logic rst_n;

  logic       req0_valid, req0_ready, req0_we;
  logic [7:0] req0_addr, req0_wdata;
  logic       rsp0_valid, rsp0_err;
  logic [7:0] rsp0_rdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [7:0] req1_addr, req1_wdata;
  logic       rsp1_valid, rsp1_err;
  logic [7:0] rsp1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout = 8'h00;
  logic       ram_tx_valid = 1'b0;
  logic [2:0] dbg_state;

  logic       f_req0_valid, f_req0_ready, f_req0_we;
  logic [7:0] f_req0_addr, f_req0_wdata;
  logic       f_rsp0_valid, f_rsp0_err;
  logic [7:0] f_rsp0_rdata;
  logic       f_req1_valid, f_req1_ready, f_req1_we;
  logic [7:0] f_req1_addr, f_req1_wdata;
  logic       f_rsp1_valid, f_rsp1_err;
  logic [7:0] f_rsp1_rdata;
  logic [9:0] f_ram_din;
  logic       f_ram_rx_valid;
  logic [7:0] f_ram_dout;
  logic       f_ram_tx_valid;
  logic [2:0] f_dbg_state;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [256];
  logic [7:0] ram_ptr = 8'h00;
  logic [7:0] rd_ptr = 8'h00;
  logic       ram_mute;
  logic [9:0] cmd_log[$];
  logic [9:0] exp_q[$];

  ram_cmd_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(4), .RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .dbg_state(dbg_state)
  );

  ram_cmd_arbiter #(.ADDR_SIZE(8), .RD_TIMEOUT(4), .RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_we(f_req0_we),
    .req0_addr(f_req0_addr), .req0_wdata(f_req0_wdata),
    .rsp0_valid(f_rsp0_valid), .rsp0_rdata(f_rsp0_rdata), .rsp0_err(f_rsp0_err),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_we(f_req1_we),
    .req1_addr(f_req1_addr), .req1_wdata(f_req1_wdata),
    .rsp1_valid(f_rsp1_valid), .rsp1_rdata(f_rsp1_rdata), .rsp1_err(f_rsp1_err),
    .ram_din(f_ram_din), .ram_rx_valid(f_ram_rx_valid),
    .ram_dout(f_ram_dout), .ram_tx_valid(f_ram_tx_valid), .dbg_state(f_dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: tx_valid stays high after a read until the next read address.
  always @(posedge clk) begin
    if (ram_rx_valid) begin
      cmd_log.push_back(ram_din);
      case (ram_din[9:8])
        2'b00: ram_ptr <= ram_din[7:0];
        2'b01: mem[ram_ptr] <= ram_din[7:0];
        2'b10: begin
          rd_ptr       <= ram_din[7:0];
          ram_tx_valid <= 1'b0;
        end
        default: begin
          if (!ram_mute) begin
            ram_dout     <= mem[rd_ptr];
            ram_tx_valid <= 1'b1;
          end
        end
      endcase
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Driver: one transaction; lat counts falling edges from the accept edge to
  // the falling edge where the owner's rsp_valid is seen.
  task automatic do_txn(input int who, input logic we, input logic [7:0] addr,
                        input logic [7:0] wd, output int lat, output logic [7:0] rd,
                        output logic er, output int other);
    bit acc;
    bit got;
    lat = 0; rd = 8'h00; er = 1'b0; other = 0; acc = 0; got = 0;
    @(negedge clk);
    if (who == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wd;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wd;
    end
    for (int k = 0; k < 20; k++) begin
      #1;
      if ((who == 0) ? req0_ready : req1_ready) begin
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    if (!acc) begin
      checks++; failures++;
      $display("FAIL accept_timeout req%0d got ready=0 required ready=1", who);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr = ~addr; req0_wdata = ~wd; req1_addr = ~addr; req1_wdata = ~wd;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if ((who == 0) ? rsp1_valid : rsp0_valid) other++;
      if ((who == 0) ? rsp0_valid : rsp1_valid) begin
        rd  = (who == 0) ? rsp0_rdata : rsp1_rdata;
        er  = (who == 0) ? rsp0_err : rsp1_err;
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL rsp_timeout req%0d got no rsp_valid required one", who);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({ram_rx_valid, ram_din} !== 11'h000) begin
      failures++;
      $display("FAIL reset_ram got rx_valid=%b din=%h required 0/000", ram_rx_valid, ram_din);
    end
    checks++;
    if ({rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata} !== 20'h0) begin
      failures++;
      $display("FAIL reset_rsp got v0=%b e0=%b d0=%h v1=%b e1=%b d1=%h required all 0",
               rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata);
    end
    checks++;
    if (dbg_state !== 3'd0 || f_dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got %0d/%0d required 0/0", dbg_state, f_dbg_state);
    end
  endtask

  task automatic test_write_read();
    int lat; logic [7:0] rd; logic er; int other; int bad;
    cmd_log.delete();
    exp_q.delete();
    exp_q.push_back(10'h03C); exp_q.push_back(10'h1A5);
    exp_q.push_back(10'h23C); exp_q.push_back(10'h300);
    do_txn(0, 1'b1, 8'h3C, 8'hA5, lat, rd, er, other);
    checks++;
    if (lat != 3 || rd !== 8'h00 || er !== 1'b0 || other != 0) begin
      failures++;
      $display("FAIL write_rsp got lat=%0d rdata=%h err=%b other=%0d required 3/00/0/0", lat, rd, er, other);
    end
    do_txn(0, 1'b0, 8'h3C, 8'h00, lat, rd, er, other);
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL read_latency got %0d required 4", lat);
    end
    checks++;
    if (rd !== 8'hA5 || er !== 1'b0 || other != 0) begin
      failures++;
      $display("FAIL read_rsp got rdata=%h err=%b other=%0d required A5/0/0", rd, er, other);
    end
    bad = 0;
    if (cmd_log.size() != exp_q.size()) bad = 99;
    else for (int i = 0; i < exp_q.size(); i++) if (cmd_log[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL ram_cmd_seq got %0d words (%0d wrong) required 4 words 03C 1A5 23C 300",
               cmd_log.size(), bad);
    end
    @(negedge clk);
    checks++;
    if (ram_rx_valid !== 1'b0 || ram_din !== 10'h000 || rsp0_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_outputs got rx_valid=%b din=%h rsp0_valid=%b required 0/000/0",
               ram_rx_valid, ram_din, rsp0_valid);
    end
  endtask

  task automatic test_round_robin();
    int grants[4]; int gcount; int rcount; int owner_err; int pending;
    int exp_g[4];
    exp_g = '{0, 1, 0, 1};
    gcount = 0; rcount = 0; owner_err = 0; pending = -1;
    apply_reset();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h10; req0_wdata = 8'h11;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h20; req1_wdata = 8'h22;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (req0_ready && req1_ready) owner_err++;
      if (req0_ready || req1_ready) begin
        pending = req1_ready ? 1 : 0;
        if (gcount < 4) grants[gcount] = pending;
        gcount++;
      end
      if (rsp0_valid || rsp1_valid) begin
        rcount++;
        if ((rsp0_valid && rsp1_valid) || (rsp1_valid ? 1 : 0) != pending) owner_err++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++;
    if (gcount != 4) begin
      failures++;
      $display("FAIL rr_grant_count got %0d required 4", gcount);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i < gcount && grants[i] != exp_g[i]) begin
        failures++;
        $display("FAIL rr_grant_%0d got req%0d required req%0d", i, grants[i], exp_g[i]);
      end
    end
    checks++;
    if (rcount != 4 || owner_err != 0) begin
      failures++;
      $display("FAIL rr_rsp_owner got rsps=%0d owner_errors=%0d required 4/0", rcount, owner_err);
    end
  endtask

  task automatic test_fixed_priority();
    int g0; int g1; int r0; int r1; bit rdy1; bit got1;
    g0 = 0; g1 = 0; r0 = 0; r1 = 0; got1 = 0;
    @(negedge clk);
    f_req0_valid = 1'b1; f_req0_we = 1'b1; f_req0_addr = 8'h01; f_req0_wdata = 8'h0A;
    f_req1_valid = 1'b1; f_req1_we = 1'b1; f_req1_addr = 8'h02; f_req1_wdata = 8'h0B;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (f_req0_ready) g0++;
      if (f_req1_ready) g1++;
      if (f_rsp0_valid) r0++;
      if (f_rsp1_valid) r1++;
      @(negedge clk);
    end
    f_req0_valid = 1'b0;
    #1;
    rdy1 = f_req1_ready;
    checks++;
    if (g0 != 3 || r0 != 3) begin
      failures++;
      $display("FAIL fp_req0_grants got grants=%0d rsps=%0d required 3/3", g0, r0);
    end
    checks++;
    if (g1 != 0 || r1 != 0) begin
      failures++;
      $display("FAIL fp_req1_starved got grants=%0d rsps=%0d required 0/0", g1, r1);
    end
    checks++;
    if (rdy1 !== 1'b1) begin
      failures++;
      $display("FAIL fp_req1_ready got %b required 1", rdy1);
    end
    @(posedge clk);
    #1;
    f_req1_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (f_rsp1_valid) begin
        got1 = 1;
        break;
      end
    end
    checks++;
    if (!got1) begin
      failures++;
      $display("FAIL fp_req1_rsp got none required one rsp1_valid");
    end
  endtask

  task automatic test_timeout();
    int lat; logic [7:0] rd; logic er; int other;
    ram_mute = 1'b1;
    do_txn(0, 1'b0, 8'h55, 8'h00, lat, rd, er, other);
    checks++;
    if (lat != 7 || er !== 1'b1 || rd !== 8'h00 || other != 0) begin
      failures++;
      $display("FAIL read_timeout got lat=%0d err=%b rdata=%h other=%0d required 7/1/00/0", lat, er, rd, other);
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== 3'd0 || rsp0_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle got state=%0d rsp0_valid=%b required 0/0", dbg_state, rsp0_valid);
    end
    ram_mute = 1'b0;
  endtask

  task automatic test_stale_tx_valid();
    int lat; logic [7:0] rd; logic er; int other;
    do_txn(1, 1'b0, 8'h3C, 8'h00, lat, rd, er, other);
    checks++;
    if (rd !== 8'hA5 || er !== 1'b0 || lat != 4) begin
      failures++;
      $display("FAIL req1_read got rdata=%h err=%b lat=%0d required A5/0/4", rd, er, lat);
    end
    do_txn(1, 1'b1, 8'h40, 8'h77, lat, rd, er, other);
    checks++;
    if (rd !== 8'h00 || er !== 1'b0 || lat != 3 || other != 0) begin
      failures++;
      $display("FAIL stale_write_rsp got rdata=%h err=%b lat=%0d other=%0d required 00/0/3/0", rd, er, lat, other);
    end
    do_txn(0, 1'b0, 8'h40, 8'h00, lat, rd, er, other);
    checks++;
    if (rd !== 8'h77 || er !== 1'b0) begin
      failures++;
      $display("FAIL readback_40 got rdata=%h err=%b required 77/0", rd, er);
    end
  endtask

  task automatic test_reset_mid_read();
    int stray; bit got0; bit got1; bit acc;
    stray = 0; got0 = 0; got1 = 0; acc = 0;
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h3C;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (req0_ready) begin
        acc = 1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (!acc || dbg_state !== 3'd3 || ram_din !== 10'h300 || ram_rx_valid !== 1'b1) begin
      failures++;
      $display("FAIL cmd_read_word got acc=%0d state=%0d din=%h rx_valid=%b required 1/3/300/1",
               acc, dbg_state, ram_din, ram_rx_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_rx_valid, ram_din, rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid, rsp1_err, rsp1_rdata} !== 31'h0
        || dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL mid_reset_outputs got rx=%b din=%h v0=%b d0=%h v1=%b d1=%h state=%0d required all 0",
               ram_rx_valid, ram_din, rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata, dbg_state);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL no_rsp_after_reset got %0d pulses required 0", stray);
    end
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h50; req0_wdata = 8'h5A;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h60; req1_wdata = 8'h6A;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      failures++;
      $display("FAIL first_grant_after_reset got ready0=%b ready1=%b required 1/0", req0_ready, req1_ready);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp1_valid) got1 = 1;
      if (rsp0_valid) begin
        got0 = 1;
        break;
      end
    end
    checks++;
    if (!got0 || got1) begin
      failures++;
      $display("FAIL post_reset_rsp got rsp0=%0d rsp1=%0d required 1/0", got0, got1);
    end
  endtask

  initial begin
    rst_n = 1'b0; ram_mute = 1'b0;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = 8'h00;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 8'h00; req1_wdata = 8'h00;
    f_req0_valid = 1'b0; f_req0_we = 1'b0; f_req0_addr = 8'h00; f_req0_wdata = 8'h00;
    f_req1_valid = 1'b0; f_req1_we = 1'b0; f_req1_addr = 8'h00; f_req1_wdata = 8'h00;
    f_ram_dout = 8'h00; f_ram_tx_valid = 1'b0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_fixed_priority();
    test_timeout();
    test_stale_tx_valid();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish required finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
